// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults and derived constants for sync_fifo.
// Holds the depth helper used to size pointers and storage.
package sync_fifo_pkg;

    localparam int C_DATA_WIDTH      = 8;
    localparam int C_FIFO_DEPTH_BITS = 4;
    localparam int C_DEPTH           = 2 ** C_FIFO_DEPTH_BITS;
    localparam int C_PTR_WIDTH       = C_FIFO_DEPTH_BITS + 1;
    localparam int C_AFULL_THRESH    = C_DEPTH - 2;
    localparam int C_AEMPTY_THRESH   = 2;

    function automatic int fifo_depth(input int depth_bits);
        return 2 ** depth_bits;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: bundle of the FIFO request and status signals.
// The master drives requests; the slave drives data and status.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int P_DATA_WIDTH      = C_DATA_WIDTH,
    parameter int P_FIFO_DEPTH_BITS = C_FIFO_DEPTH_BITS
);

    logic                         wr_en;
    logic [P_DATA_WIDTH-1:0]      wr_data;
    logic                         rd_en;
    logic [P_DATA_WIDTH-1:0]      rd_data;
    logic                         rd_valid;
    logic                         full;
    logic                         empty;
    logic                         afull;
    logic                         aempty;
    logic [P_FIFO_DEPTH_BITS:0]   level;
    logic                         overflow;
    logic                         underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty,
        input  afull, aempty, level, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty,
        output afull, aempty, level, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: simple dual-port storage, one write port and one
// registered read port; the array itself is never cleared.
module sync_fifo_mem #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_wr_en,
    input  logic [P_ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [P_DATA_WIDTH-1:0] i_wr_data,
    input  logic                    i_rd_en,
    input  logic [P_ADDR_WIDTH-1:0] i_rd_addr,
    output logic [P_DATA_WIDTH-1:0] o_rd_data
);

    logic [P_DATA_WIDTH-1:0] r_mem [2**P_ADDR_WIDTH];
    logic [P_DATA_WIDTH-1:0] r_rd_data;

    // Write port: store the word when the write is accepted.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: capture on accepted read, hold otherwise.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with level and almost flags.
// Optional sticky error flags under SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int P_DATA_WIDTH      = C_DATA_WIDTH,
    parameter int P_FIFO_DEPTH_BITS = C_FIFO_DEPTH_BITS,
    parameter int P_AFULL_THRESH    = 2 ** P_FIFO_DEPTH_BITS - 2,
    parameter int P_AEMPTY_THRESH   = C_AEMPTY_THRESH
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_wr_en,
    input  logic [P_DATA_WIDTH-1:0]      i_wr_data,
    input  logic                         i_rd_en,
    output logic [P_DATA_WIDTH-1:0]      o_rd_data,
    output logic                         o_rd_valid,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_afull,
    output logic                         o_aempty,
    output logic [P_FIFO_DEPTH_BITS:0]   o_level,
    output logic                         o_overflow,
    output logic                         o_underflow
);

    localparam int LP_DEPTH = fifo_depth(P_FIFO_DEPTH_BITS);
    localparam int LP_PW    = P_FIFO_DEPTH_BITS + 1;
    localparam int LP_AW    = P_FIFO_DEPTH_BITS;

    localparam logic [LP_PW-1:0] LP_DEPTH_L  = LP_PW'(LP_DEPTH);
    localparam logic [LP_PW-1:0] LP_AFULL_L  = LP_PW'(P_AFULL_THRESH);
    localparam logic [LP_PW-1:0] LP_AEMPTY_L = LP_PW'(P_AEMPTY_THRESH);

    if (P_AFULL_THRESH > LP_DEPTH) begin : g_bad_afull
        $error("sync_fifo: P_AFULL_THRESH exceeds depth");
    end
    if (P_AEMPTY_THRESH > LP_DEPTH) begin : g_bad_aempty
        $error("sync_fifo: P_AEMPTY_THRESH exceeds depth");
    end

    logic [LP_PW-1:0] r_wr_ptr;
    logic [LP_PW-1:0] r_rd_ptr;
    logic             r_rd_valid;
    logic [LP_PW-1:0] w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // Status is derived from the registered pointers only.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_level == LP_DEPTH_L);
    assign w_empty = (w_level == '0);

    // Requests during reset are ignored, rejected ones never move state.
    assign w_wr_acc = i_rst_n & i_wr_en & ~w_full;
    assign w_rd_acc = i_rst_n & i_rd_en & ~w_empty;

    // Pointer and read-valid registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_rd_valid <= w_rd_acc;
        end
    end

    sync_fifo_mem #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_ADDR_WIDTH (LP_AW)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[LP_AW-1:0]),
        .i_wr_data (i_wr_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr[LP_AW-1:0]),
        .o_rd_data (o_rd_data)
    );

    assign o_rd_valid = r_rd_valid;
    assign o_level    = w_level;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_afull    = (w_level >= LP_AFULL_L);
    assign o_aempty   = (w_level <= LP_AEMPTY_L);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky misuse flags, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (i_rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
`else
    assign o_overflow  = 1'b0;
    assign o_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed plus random stimulus against a queue model.
// Every cycle all outputs are compared with the model's expectation.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DB    = 4;
    localparam int DEPTH = 16;
    localparam int AFULL = DEPTH - 2;
    localparam int AEMPT = 2;

    logic clk;
    logic rst_n;

    sync_fifo_if #(.P_DATA_WIDTH(DW), .P_FIFO_DEPTH_BITS(DB)) bus ();

    sync_fifo dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wr_en     (bus.wr_en),
        .i_wr_data   (bus.wr_data),
        .i_rd_en     (bus.rd_en),
        .o_rd_data   (bus.rd_data),
        .o_rd_valid  (bus.rd_valid),
        .o_full      (bus.full),
        .o_empty     (bus.empty),
        .o_afull     (bus.afull),
        .o_aempty    (bus.aempty),
        .o_level     (bus.level),
        .o_overflow  (bus.overflow),
        .o_underflow (bus.underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ovf;
    logic          m_unf;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic compare_all();
        int n;
        n = q.size();
        check("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
        check("rd_data", 32'(bus.rd_data), 32'(m_data));
        check("level", 32'(bus.level), n);
        check("full", 32'(bus.full), 32'(n == DEPTH));
        check("empty", 32'(bus.empty), 32'(n == 0));
        check("afull", 32'(bus.afull), 32'(n >= AFULL));
        check("aempty", 32'(bus.aempty), 32'(n <= AEMPT));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("underflow", 32'(bus.underflow), 32'(m_unf));
`else
        check("overflow", 32'(bus.overflow), 32'd0);
        check("underflow", 32'(bus.underflow), 32'd0);
`endif
    endtask

    // One clock: drive, update the model from pre-edge state, compare.
    task automatic step(input bit rn, input bit wr,
                        input logic [DW-1:0] wd, input bit rd);
        int  n;
        bit  do_wr;
        bit  do_rd;
        rst_n       = rn;
        bus.wr_en   = wr;
        bus.wr_data = wd;
        bus.rd_en   = rd;
        @(posedge clk);
        #1;
        cyc++;
        n = q.size();
        if (!rn) begin
            q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            do_wr = wr && (n < DEPTH);
            do_rd = rd && (n > 0);
            if (wr && n == DEPTH) m_ovf = 1'b1;
            if (rd && n == 0) m_unf = 1'b1;
            m_valid = do_rd;
            if (do_rd) m_data = q.pop_front();
            if (do_wr) q.push_back(wd);
        end
        compare_all();
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;

        step(0, 0, 8'h00, 0);
        step(0, 1, 8'h33, 1);

        for (int i = 0; i < 16; i++) step(1, 1, 8'(i), 0);
        step(1, 1, 8'hAA, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 0);

        step(1, 1, 8'h55, 1);
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 0);

        for (int i = 0; i < 8; i++) step(1, 1, 8'(8'h40 + i), 0);
        for (int i = 0; i < 40; i++) step(1, 1, 8'(8'h80 + i), 1);
        for (int i = 0; i < 8; i++) step(1, 0, 8'h00, 1);

        for (int i = 0; i < 16; i++) step(1, 1, 8'(8'hC0 + i), 0);
        step(1, 1, 8'hEE, 1);
        for (int i = 0; i < 16; i++) step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 0);

        step(0, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);

        for (int i = 0; i < 9; i++) step(1, 1, 8'(8'h10 + i), 0);
        step(0, 1, 8'h99, 1);
        step(1, 0, 8'h00, 0);

        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 99) < 55),
                 8'($urandom),
                 ($urandom_range(0, 99) < 45));
        end

        step(0, 0, 8'h00, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
